// File: rtl/gf_inv4_pipe.sv
// Two-stage pipelined GF(2^4) inverter (Canright normal basis) with valid/ready on both sides.
// Define GF_INV4_ZFLAG_EN to carry an X==0 flag through the pipe and expose it on zero_o.
module gf_inv4_muls2 (
    input  logic [1:0] a,
    input  logic       ab,
    input  logic [1:0] b,
    input  logic       cd,
    output logic [1:0] y
);
    logic k;

    // Shared factor: the (a1^a0)&(b1^b0) term is supplied precomputed by the caller.
    assign k = ~(ab & cd);
    assign y = {~(a[1] & b[1]) ^ k, ~(a[0] & b[0]) ^ k};
endmodule

module gf_inv4_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] X,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] Y
`ifdef GF_INV4_ZFLAG_EN
    ,
    output logic       zero_o
`endif
);
    typedef struct packed {
        logic [1:0] d;
        logic       sd;
        logic [1:0] a;
        logic       sa;
        logic [1:0] b;
        logic       sb;
`ifdef GF_INV4_ZFLAG_EN
        logic       z;
`endif
    } s1_t;

    typedef struct packed {
        logic [3:0] y;
`ifdef GF_INV4_ZFLAG_EN
        logic       z;
`endif
    } s2_t;

    logic [2:1] vld_pipe;
    logic       adv1, adv2, acc;
    s1_t        s1, s1_nxt;
    s2_t        s2, s2_nxt;

    logic [1:0] a, b, c;
    logic       sa, sb;

    assign adv2     = ~vld_pipe[2] | out_ready;
    assign adv1     = ~vld_pipe[1] | adv2;
    assign in_ready = adv1;
    assign acc      = in_valid & adv1;

    // Stage 1: GF(2^2) inverse of the norm term is just a bit swap.
    assign a  = X[3:2];
    assign b  = X[1:0];
    assign sa = a[1] ^ a[0];
    assign sb = b[1] ^ b[0];
    assign c  = {~(a[1] | b[1]) ^ ~(sa & sb), ~(sa | sb) ^ ~(a[0] & b[0])};

    always_comb begin
        s1_nxt    = '0;
        s1_nxt.d  = {c[0], c[1]};
        s1_nxt.sd = c[0] ^ c[1];
        s1_nxt.a  = a;
        s1_nxt.sa = sa;
        s1_nxt.b  = b;
        s1_nxt.sb = sb;
`ifdef GF_INV4_ZFLAG_EN
        s1_nxt.z  = (X == 4'h0);
`endif
    end

    // Stage 2: lane 1 yields p = d*b, lane 0 yields q = d*a.
    logic [1:0][1:0] mul_a, mul_b, mul_y;
    logic [1:0]      mul_ab, mul_cd;

    assign mul_a  = {2{s1.d}};
    assign mul_ab = {2{s1.sd}};
    assign mul_b  = {s1.b, s1.a};
    assign mul_cd = {s1.sb, s1.sa};

    gf_inv4_muls2 u_mul [1:0] (
        .a  (mul_a),
        .ab (mul_ab),
        .b  (mul_b),
        .cd (mul_cd),
        .y  (mul_y)
    );

    always_comb begin
        s2_nxt   = '0;
        s2_nxt.y = mul_y;
`ifdef GF_INV4_ZFLAG_EN
        s2_nxt.z = s1.z;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1       <= '0;
            s2       <= '0;
        end else begin
            if (adv2) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) s2 <= s2_nxt;
            end
            if (adv1) begin
                vld_pipe[1] <= acc;
                if (acc) s1 <= s1_nxt;
            end
        end
    end

    assign out_valid = vld_pipe[2];
    assign Y         = s2.y;
`ifdef GF_INV4_ZFLAG_EN
    assign zero_o    = s2.z;
`endif
endmodule

// File: tb/tb_gf_inv4_pipe.sv
// Randomized/directed bench for gf_inv4_pipe with a queue scoreboard and a table-driven reference.
module tb_gf_inv4_pipe;
    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, out_valid, out_ready;
    logic [3:0] X, Y;
`ifdef GF_INV4_ZFLAG_EN
    logic       zero_o;
`endif

    int         n_chk = 0;
    int         n_err = 0;
    int         n_pop = 0;
    logic [3:0] ref_tbl [16];
    logic [3:0] dut_res [16];
    logic [7:0] exp_q [$];

    gf_inv4_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y)
`ifdef GF_INV4_ZFLAG_EN
        ,
        .zero_o    (zero_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: evaluate the field equations on plain integers.
    function automatic int mul2(input int a1, a0, ab, b1, b0, cd);
        int k;
        k = 1 - (ab & cd);
        return (((1 - (a1 & b1)) ^ k) << 1) | ((1 - (a0 & b0)) ^ k);
    endfunction

    function automatic int model_inv(input int x);
        int a1, a0, b1, b0, sa, sb, c1, c0, d1, d0, sd, p, q;
        a1 = (x >> 3) & 1; a0 = (x >> 2) & 1;
        b1 = (x >> 1) & 1; b0 = x & 1;
        sa = a1 ^ a0; sb = b1 ^ b0;
        c1 = (1 - (a1 | b1)) ^ (1 - (sa & sb));
        c0 = (1 - (sa | sb)) ^ (1 - (a0 & b0));
        d1 = c0; d0 = c1; sd = d1 ^ d0;
        p = mul2(d1, d0, sd, b1, b0, sb);
        q = mul2(d1, d0, sd, a1, a0, sa);
        return (p << 2) | q;
    endfunction

    task automatic tick();
        logic       stall;
        logic [3:0] y_hold;
        logic [7:0] e;
        @(negedge clk);
        stall  = out_valid && !out_ready;
        y_hold = Y;
        if (in_valid && in_ready) exp_q.push_back({X, ref_tbl[X]});
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                n_pop++;
                chk("y", 32'(Y), 32'(e[3:0]));
`ifdef GF_INV4_ZFLAG_EN
                chk("zflag", 32'(zero_o), 32'(e[7:4] == 4'h0));
`endif
                dut_res[e[7:4]] = Y;
            end
        end
        @(posedge clk); #1;
        if (stall) begin
            chk("hold_v", 32'(out_valid), 32'd1);
            chk("hold_y", 32'(Y), 32'(y_hold));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [3:0] sx [4] = '{4'hF, 4'h1, 4'hC, 4'h0};
        logic [3:0] sy [4] = '{4'hF, 4'hC, 4'h1, 4'h0};
        logic [3:0] bp [3];
        logic       pat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       ov [6];
        logic [3:0] yv [6];
        int         idx, p0;

        for (int i = 0; i < 16; i++) ref_tbl[i] = 4'(model_inv(i));
        for (int i = 0; i < 16; i++) dut_res[i] = 4'h0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; X = 4'h0;
        #12;
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(Y), 32'd0);
`ifdef GF_INV4_ZFLAG_EN
        chk("rst_z", 32'(zero_o), 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_rdy", 32'(in_ready), 32'd1);

        // Single operations against hand-known vectors.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            X = sx[i]; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("lat1_v", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
            chk("lat2_v", 32'(out_valid), 32'd1);
            chk("single_y", 32'(Y), 32'(sy[i]));
`ifdef GF_INV4_ZFLAG_EN
            chk("single_z", 32'(zero_o), 32'(sx[i] == 4'h0));
`endif
        end
        @(posedge clk); #1;
        chk("single_idle", 32'(out_valid), 32'd0);

        // Exhaustive back-to-back streaming.
        p0 = n_pop;
        for (int x = 0; x < 16; x++) begin
            X = 4'(x); in_valid = 1'b1;
            chk("stream_rdy", 32'(in_ready), 32'd1);
            tick();
        end
        chk("stream_tput", 32'(n_pop - p0), 32'd14);
        drain();
        for (int x = 0; x < 16; x++)
            chk("involution", 32'(dut_res[dut_res[x]]), 32'(x));
        chk("zero_map", 32'(dut_res[0]), 32'd0);

        // Backpressure: two accepted, third refused, then released.
        for (int i = 0; i < 3; i++) bp[i] = 4'($urandom_range(1, 15));
        out_ready = 1'b0; in_valid = 1'b1; idx = 0;
        for (int c = 0; c < 3; c++) begin
            X = bp[idx];
            chk("bp_rdy", 32'(in_ready), 32'(c < 2));
            if (in_ready) idx++;
            tick();
        end
        chk("bp_acc", 32'(idx), 32'd2);
        for (int c = 0; c < 3; c++) tick();
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_rise", 32'(in_ready), 32'd1);
        while (idx < 3) begin
            X = bp[idx];
            idx++;
            tick();
        end
        drain();

        // Bubbles: out_valid should mirror the input pattern one accept-stage later.
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = pat[k];
            X = 4'($urandom_range(0, 15));
            tick();
            ov[k] = out_valid;
            yv[k] = Y;
        end
        chk("bub_v0", 32'(ov[0]), 32'd0);
        for (int k = 1; k < 6; k++) begin
            chk("bub_v", 32'(ov[k]), 32'(pat[k-1]));
            if (k >= 2 && !pat[k-1]) chk("bub_y", 32'(yv[k]), 32'(yv[k-1]));
        end
        drain();

        // Random traffic with random backpressure.
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            X = 4'($urandom_range(0, 15));
            tick();
        end
        drain();

        // Asynchronous reset with both stages full.
        out_ready = 1'b0; in_valid = 1'b1;
        X = 4'h5; tick();
        X = 4'h9; tick();
        in_valid = 1'b0;
        chk("full_v", 32'(out_valid), 32'd1);
        chk("full_rdy", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_v", 32'(out_valid), 32'd0);
        chk("arst_y", 32'(Y), 32'd0);
`ifdef GF_INV4_ZFLAG_EN
        chk("arst_z", 32'(zero_o), 32'd0);
`endif
        exp_q.delete();
        #1 rst = 1'b0;
        #1;
        chk("arst_rdy", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("arst_stale", 32'(out_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
